// File: rtl/lsu_pkg.sv
// Shared encodings, request payload and helpers for the byte-serial load/store unit.
package lsu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 3;
  localparam int unsigned CNT_W  = 2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_e;

  typedef struct packed {
    logic              write;
    logic [1:0]        size;
    logic              sgn;
    logic [DATA_W-1:0] wdata;
  } req_t;

  function automatic logic [LEN_W-1:0] size_to_len(input logic [1:0] size);
    case (size)
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  // Big-endian byte order: access idx 0 carries the most significant byte of the N-byte value.
  function automatic logic [7:0] store_byte(input logic [DATA_W-1:0] wdata,
                                            input logic [LEN_W-1:0]  len,
                                            input logic [CNT_W-1:0]  idx);
    logic [LEN_W-1:0] k;
    k = len - 3'd1 - LEN_W'(idx);
    return 8'(wdata >> {k[1:0], 3'b000});
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of the assembled load bytes according to access size.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] shift_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  output logic [DATA_W-1:0] ext_data_c
);

  always_comb begin
    ext_data_c = shift_i;
    case (size_i)
      SZ_BYTE: ext_data_c = {{24{signed_i & shift_i[7]}}, shift_i[7:0]};
      SZ_HALF: ext_data_c = {{16{signed_i & shift_i[15]}}, shift_i[15:0]};
      default: ext_data_c = shift_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Serialises byte/half/word loads and stores onto a byte-wide big-endian memory port.
// Define LSU_BOUNDS_CHECK_EN to reject accesses that run past MEM_BYTES.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_BYTES = 64
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [1:0]        ReqSize,
  input  logic              ReqSigned,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [DATA_W-1:0] ReqWData,
  output logic              RespValid,
  output logic [DATA_W-1:0] RespRData,
  output logic              RespErr,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemWE,
  output logic [7:0]        MemWData,
  input  logic [7:0]        MemRData
);

  localparam int unsigned EXT_W = ADDR_W + 1;
`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  req_t               req_q, req_d;
  logic [DATA_W-1:0]  shift_q, shift_d;

  logic               req_ready_q, req_ready_d;
  logic               resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]  resp_rdata_q, resp_rdata_d;
  logic               resp_err_q, resp_err_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               mem_we_q, mem_we_d;
  logic [7:0]         mem_wdata_q, mem_wdata_d;

  logic [LEN_W-1:0]   len_c;
  logic               misalign_c, oob_c, req_err_c, last_c;
  logic [DATA_W-1:0]  ext_c;

  // Request legality check, evaluated on the live request in IDLE
  always_comb begin
    len_c      = size_to_len(ReqSize);
    misalign_c = (ReqSize == 2'b11)
               | ((ReqSize == SZ_HALF) & ReqAddr[0])
               | ((ReqSize == SZ_WORD) & (ReqAddr[1:0] != 2'b00));
    oob_c      = ({1'b0, ReqAddr} + EXT_W'(len_c)) > EXT_W'(MEM_BYTES);
    req_err_c  = misalign_c | (BOUNDS_EN & oob_c);
  end

  assign last_c = (LEN_W'(cnt_q) == (len_q - 3'd1));

  // Extension operates on the post-shift value so the final byte lands in the response
  lsu_extend u_extend (
    .shift_i    (shift_d),
    .size_i     (req_q.size),
    .signed_i   (req_q.sgn),
    .ext_data_c (ext_c)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    addr_d       = addr_q;
    req_d        = req_q;
    shift_d      = shift_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    mem_addr_d   = '0;
    mem_we_d     = 1'b0;
    mem_wdata_d  = '0;
    case (state_q)
      IDLE: begin
        if (ReqValid) begin
          req_d  = '{write: ReqWrite, size: ReqSize, sgn: ReqSigned, wdata: ReqWData};
          addr_d = ReqAddr;
          len_d  = len_c;
          cnt_d  = '0;
          if (req_err_c) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d     = XFER;
            shift_d     = '0;
            mem_addr_d  = ReqAddr;
            mem_we_d    = ReqWrite;
            mem_wdata_d = ReqWrite ? store_byte(ReqWData, len_c, '0) : 8'h00;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      XFER: begin
        if (!req_q.write) begin
          shift_d = {shift_q[DATA_W-9:0], MemRData};
        end
        if (last_c) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = req_q.write ? '0 : ext_c;
        end else begin
          cnt_d       = cnt_q + 2'd1;
          mem_addr_d  = addr_q + ADDR_W'(cnt_d);
          mem_we_d    = req_q.write;
          mem_wdata_d = req_q.write ? store_byte(req_q.wdata, len_q, cnt_d) : 8'h00;
        end
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      addr_q       <= '0;
      req_q        <= '0;
      shift_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      shift_q      <= shift_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign ReqReady  = req_ready_q;
  assign RespValid = resp_valid_q;
  assign RespRData = resp_rdata_q;
  assign RespErr   = resp_err_q;
  assign MemAddr   = mem_addr_q;
  assign MemWE     = mem_we_q;
  assign MemWData  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-wide behavioural data memory.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic        ReqWrite = 1'b0;
  logic [1:0]  ReqSize = 2'b00;
  logic        ReqSigned = 1'b0;
  logic [31:0] ReqAddr = '0;
  logic [31:0] ReqWData = '0;
  logic        RespValid;
  logic [31:0] RespRData;
  logic        RespErr;
  logic [31:0] MemAddr;
  logic        MemWE;
  logic [7:0]  MemWData;
  logic [7:0]  MemRData;

  logic [7:0]  mem [256];
  logic [31:0] w_addr [4];
  logic [7:0]  w_data [4];
  int          n_wr;
  int          checks = 0;
  int          errors = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (MemWE) mem[MemAddr[7:0]] = MemWData;
  assign MemRData = mem[MemAddr[7:0]];

  load_store_unit #(.ADDR_W(32), .MEM_BYTES(64)) dut (
    .CLK(CLK), .Reset(Reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
    .RespValid(RespValid), .RespRData(RespRData), .RespErr(RespErr),
    .MemAddr(MemAddr), .MemWE(MemWE), .MemWData(MemWData), .MemRData(MemRData)
  );

  // Issues one request and returns the response plus latency counted from the accept edge
  task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat);
    int guard;
    guard = 0;
    while (!ReqReady && guard < 20) begin
      @(posedge CLK); #1; guard++;
    end
    ReqValid = 1'b1; ReqWrite = wr; ReqSize = sz; ReqSigned = sg; ReqAddr = addr; ReqWData = wd;
    @(posedge CLK); #1;
    ReqValid = 1'b0;
    n_wr = 0;
    lat = 1;
    while (!RespValid && lat < 20) begin
      if (MemWE) begin
        if (n_wr < 4) begin
          w_addr[n_wr] = MemAddr;
          w_data[n_wr] = MemWData;
        end
        n_wr++;
      end
      @(posedge CLK); #1; lat++;
    end
    if (RespValid) begin
      rd = RespRData; er = RespErr;
    end else begin
      rd = 32'hDEAD_DEAD; er = 1'bx; lat = 99;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    Reset = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (ReqReady !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b exp 1", ReqReady);
    end
    checks++;
    if ({RespValid, RespRData, RespErr, MemAddr, MemWE, MemWData} !== 75'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%h e=%b a=%h we=%b wd=%h exp all 0",
               RespValid, RespRData, RespErr, MemAddr, MemWE, MemWData);
    end
    Reset = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_load_word();
    logic [31:0] rd; logic er; int lat;
    mem[8'h08] = 8'h12; mem[8'h09] = 8'h34; mem[8'h0A] = 8'h56; mem[8'h0B] = 8'h78;
    run_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h12345678) begin errors++; $display("FAIL ldw_data got %h exp 12345678", rd); end
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL ldw_latency got %0d exp 5", lat); end
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL ldw_err got %b exp 0", er); end
  endtask

  task automatic test_load_byte_half();
    logic [31:0] rd; logic er; int lat;
    mem[8'h0C] = 8'h80; mem[8'h0E] = 8'h80; mem[8'h0F] = 8'h01;
    run_req(1'b0, 2'b00, 1'b1, 32'h0C, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL ldb_signed got %h exp ffffff80", rd); end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL ldb_latency got %0d exp 2", lat); end
    run_req(1'b0, 2'b00, 1'b0, 32'h0C, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h00000080) begin errors++; $display("FAIL ldb_unsigned got %h exp 00000080", rd); end
    run_req(1'b0, 2'b01, 1'b1, 32'h0E, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL ldh_signed got %h exp ffff8001", rd); end
    run_req(1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h00008001) begin errors++; $display("FAIL ldh_unsigned got %h exp 00008001", rd); end
  endtask

  task automatic test_store_half();
    logic [31:0] rd; logic er; int lat;
    run_req(1'b1, 2'b01, 1'b0, 32'h10, 32'h0000BEEF, rd, er, lat);
    checks++;
    if (n_wr !== 2) begin errors++; $display("FAIL sth_we_cycles got %0d exp 2", n_wr); end
    checks++;
    if ({w_addr[0], w_data[0]} !== {32'h10, 8'hBE}) begin
      errors++; $display("FAIL sth_first got %h/%h exp 10/be", w_addr[0], w_data[0]);
    end
    checks++;
    if ({w_addr[1], w_data[1]} !== {32'h11, 8'hEF}) begin
      errors++; $display("FAIL sth_second got %h/%h exp 11/ef", w_addr[1], w_data[1]);
    end
    checks++;
    if ({mem[8'h10], mem[8'h11]} !== 16'hBEEF) begin
      errors++; $display("FAIL sth_mem got %h%h exp beef", mem[8'h10], mem[8'h11]);
    end
    checks++;
    if ({rd, er, lat} !== {32'h0, 1'b0, 32'd3}) begin
      errors++; $display("FAIL sth_resp got d=%h e=%b lat=%0d exp d=0 e=0 lat=3", rd, er, lat);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    run_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, rd, er, lat);
    checks++;
    if ({er, lat} !== {1'b1, 32'd1}) begin
      errors++; $display("FAIL err_misword got e=%b lat=%0d exp e=1 lat=1", er, lat);
    end
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL err_misword_data got %h exp 0", rd); end
    run_req(1'b1, 2'b11, 1'b0, 32'h08, 32'h12345678, rd, er, lat);
    checks++;
    if ({er, lat, rd} !== {1'b1, 32'd1, 32'h0}) begin
      errors++; $display("FAIL err_size11 got e=%b lat=%0d d=%h exp e=1 lat=1 d=0", er, lat, rd);
    end
    checks++;
    if (n_wr !== 0 || mem[8'h08] !== 8'h12) begin
      errors++; $display("FAIL err_no_write got we_cycles=%0d mem08=%h exp 0/12", n_wr, mem[8'h08]);
    end
    run_req(1'b1, 2'b01, 1'b0, 32'h05, 32'h1234, rd, er, lat);
    checks++;
    if ({er, lat, n_wr} !== {1'b1, 32'd1, 32'd0}) begin
      errors++; $display("FAIL err_mishalf got e=%b lat=%0d we=%0d exp e=1 lat=1 we=0", er, lat, n_wr);
    end
  endtask

  task automatic test_reset_mid_xfer();
    logic seen;
    int guard;
    guard = 0;
    while (!ReqReady && guard < 20) begin @(posedge CLK); #1; guard++; end
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'b10; ReqSigned = 1'b0;
    ReqAddr = 32'h20; ReqWData = 32'hAABBCCDD;
    @(posedge CLK); #1;
    ReqValid = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    checks++;
    if ({MemWE, MemAddr, MemWData} !== {1'b1, 32'h22, 8'hCC}) begin
      errors++; $display("FAIL rst_xfer3 got we=%b a=%h d=%h exp 1/22/cc", MemWE, MemAddr, MemWData);
    end
    #1 Reset = 1'b0;
    #1;
    checks++;
    if ({RespValid, RespRData, RespErr, MemAddr, MemWE, MemWData} !== 75'd0) begin
      errors++;
      $display("FAIL rst_abort_outputs got v=%b d=%h e=%b a=%h we=%b wd=%h exp all 0",
               RespValid, RespRData, RespErr, MemAddr, MemWE, MemWData);
    end
    seen = 1'b0;
    repeat (3) begin
      @(posedge CLK); #1;
      if (RespValid) seen = 1'b1;
    end
    Reset = 1'b1;
    repeat (3) begin
      @(posedge CLK); #1;
      if (RespValid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_resp got %b exp 0", seen); end
    checks++;
    if ({mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]} !== 32'hAABB0000) begin
      errors++;
      $display("FAIL rst_mem got %h %h %h %h exp aa bb 00 00", mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]);
    end
    checks++;
    if (ReqReady !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", ReqReady); end
  endtask

  task automatic test_back_to_back();
    int g;
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqSize = 2'b00; ReqSigned = 1'b0; ReqAddr = 32'h08;
    @(posedge CLK); #1;
    ReqAddr = 32'h09;
    g = 0;
    while (!RespValid && g < 20) begin @(posedge CLK); #1; g++; end
    checks++;
    if (RespRData !== 32'h12 || !RespValid) begin
      errors++; $display("FAIL b2b_first got v=%b d=%h exp 1/00000012", RespValid, RespRData);
    end
    @(posedge CLK); #1;
    checks++;
    if (ReqReady !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_resp got %b exp 1", ReqReady); end
    g = 1;
    while (!RespValid && g < 20) begin @(posedge CLK); #1; g++; end
    ReqValid = 1'b0;
    checks++;
    if (g !== 3) begin errors++; $display("FAIL b2b_gap got %0d exp 3", g); end
    checks++;
    if (RespRData !== 32'h34) begin errors++; $display("FAIL b2b_second got %h exp 00000034", RespRData); end
    @(posedge CLK); #1;
  endtask

  task automatic test_bounds();
    logic [31:0] rd; logic er; int lat;
    mem[8'h3C] = 8'h01; mem[8'h3D] = 8'h02; mem[8'h3E] = 8'h03; mem[8'h3F] = 8'h04;
    run_req(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, rd, er, lat);
    checks++;
    if ({rd, er, lat} !== {32'h01020304, 1'b0, 32'd5}) begin
      errors++; $display("FAIL bnd_last_word got d=%h e=%b lat=%0d exp 01020304/0/5", rd, er, lat);
    end
    mem[8'h40] = 8'hC0; mem[8'h41] = 8'hC1; mem[8'h42] = 8'hC2; mem[8'h43] = 8'hC3;
    run_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lat);
`ifdef LSU_BOUNDS_CHECK_EN
    checks++;
    if ({rd, er, lat} !== {32'h0, 1'b1, 32'd1}) begin
      errors++; $display("FAIL bnd_past_end got d=%h e=%b lat=%0d exp 0/1/1", rd, er, lat);
    end
`else
    checks++;
    if ({rd, er, lat} !== {32'hC0C1C2C3, 1'b0, 32'd5}) begin
      errors++; $display("FAIL bnd_passthru got d=%h e=%b lat=%0d exp c0c1c2c3/0/5", rd, er, lat);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_byte_half();
    test_store_half();
    test_errors();
    test_reset_mid_xfer();
    test_back_to_back();
    test_bounds();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
